line_encoder: RTL
=================

LINE_ENCODER -- requirements
Module: line_encoder

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits; legal range 2..32.
REQ-002 Parameter STUFF_RUN, default 6: consecutive transmitted 1 bits that trigger insertion of a stuffed 0; legal range 2..15.
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port mode  input  2  encoding: 00 NRZ-L, 01 NRZI, 10 Manchester, 11 reserved and treated as NRZ-L.
REQ-006 Port stuff_en  input  1  1 enables bit stuffing.
REQ-007 Port data_in  input  WIDTH  word to transmit, MSB first.
REQ-008 Port data_valid  input  1  data_in is valid.
REQ-009 Port data_ready  output  1  encoder accepts a word this cycle.
REQ-010 Port B_out  output  1  encoded serial line, registered.
REQ-011 Port busy  output  1  a bit period (data or stuffed) is in progress.
REQ-012 Port stuff_out  output  1  high for both halves of a stuffed bit period.

Function
REQ-013 The block SHALL accept a word on a rising edge where data_valid and data_ready are both 1; mode and stuff_en are sampled on that edge and held for the whole word.
REQ-014 Every bit period SHALL last exactly 2 clk cycles: half H0, then half H1.
REQ-015 H0 of the MSB SHALL appear on B_out in the cycle immediately after the accepting edge.
REQ-016 NRZ-L: B_out SHALL equal the bit in both halves.
REQ-017 NRZI: at the start of H0, B_out SHALL toggle for a 1 and hold for a 0; the level SHALL be unchanged in H1.
REQ-018 Manchester: a 1 SHALL be sent as H0=0, H1=1; a 0 SHALL be sent as H0=1, H1=0.
REQ-019 The stuff counter SHALL count consecutive transmitted data 1s, including across back-to-back words.
- It SHALL clear on a transmitted 0, on a stuffed bit, when the block goes idle, and on reset.
REQ-020 With stuff_en=1, when the counter reaches STUFF_RUN, the next bit period SHALL be a stuffed 0.
- The stuffed 0 is encoded per mode like a data 0, with stuff_out=1.
- It is inserted even if it follows the last bit of a word.
REQ-021 data_ready SHALL be 1 when idle, and 1 during H1 of the final period of a word (last data bit, or its trailing stuffed bit); it SHALL be 0 at all other times.
REQ-022 A word accepted during that final H1 SHALL start its MSB H0 in the very next cycle, with no gap.
REQ-023 If no word is accepted at the end of a word, the block SHALL go idle: busy=0, stuff_out=0, B_out holds its last level in all modes.
REQ-024 NRZI state SHALL be the current B_out level, persisting across words and idle periods.
REQ-025 busy SHALL be 1 in every cycle in which B_out carries H0 or H1 of any bit period.
REQ-026 data_valid with data_ready=0 SHALL have no effect; data_in is not captured.
REQ-027 Implementation SHALL use an explicit state machine with states IDLE, DATA, STUFF, plus a half-bit phase flag, a bit index counter sized ceil(log2(WIDTH)), and a stuff counter sized ceil(log2(STUFF_RUN+1)).

Reset
REQ-028 While rst=1 at a rising edge, the block SHALL force: state IDLE, B_out=0, busy=0, stuff_out=0, data_ready=0, stuff counter 0, shift register 0.
REQ-029 data_ready SHALL become 1 in the first cycle after the first edge with rst=0.
REQ-030 Reset asserted mid-word SHALL abort the word at the next edge, with no further bits transmitted.

Verification
REQ-031 NRZ-L, stuff_en=0, data_in=0xA5 (WIDTH=8) -> B_out per clk 1,1,0,0,1,1,0,0,0,0,1,1,0,0,1,1; busy high for 16 cycles.
REQ-032 NRZI from B_out=0, data_in=0xA5 -> per-bit levels 1,1,0,0,0,1,1,0, each held 2 cycles.
REQ-033 Manchester, data_in=0xA5 -> B_out per clk 0,1,1,0,0,1,1,0,1,0,0,1,1,0,0,1.
REQ-034 NRZ-L, stuff_en=1, STUFF_RUN=6, data_in=0xFF:
- B_out per bit period 1,1,1,1,1,1,0,1,1 (18 cycles).
- stuff_out high only in period 7.
- data_ready high only in cycle 18.
REQ-035 Back-to-back 0xFF then 0x80, NRZ-L, stuff_en=1, data_valid held high:
- Second word accepted in the final H1 of the first word; no idle cycle between words.
- Stuff count continues across the word boundary.
REQ-036 rst pulsed for 1 cycle after bit 3 of a Manchester word -> next cycle B_out=0, busy=0; data_ready=1 one cycle later; a new word starts cleanly.

Source files
------------

// File: rtl/line_encoder.sv
// Serial line encoder: NRZ-L / NRZI / Manchester with optional zero-bit stuffing.
// Each bit period is two clk cycles (H0, H1); words are sent MSB first.
//
// state | meaning
// IDLE  | no bit period in progress, B_out holds its last level
// DATA  | transmitting a data bit (phase selects H0/H1)
// STUFF | transmitting an inserted 0 after a run of STUFF_RUN ones
module line_encoder #(
  parameter int WIDTH     = 8,
  parameter int STUFF_RUN = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             stuff_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             B_out,
  output logic             busy,
  output logic             stuff_out
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(STUFF_RUN + 1);
  localparam logic [CW-1:0] RUN = CW'(STUFF_RUN);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    STUFF = 2'd2
  } state_t;

  state_t           state, state_n;
  logic             phase, phase_n;
  logic [IW-1:0]    bit_idx, idx_n;
  logic [CW-1:0]    cnt, cnt_n, cnt_inc;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [1:0]       mode_r, mode_n, launch_mode;
  logic             sen_r, sen_n;
  logic             stuff_last, last_n;
  logic             b_reg, b_n;
  logic             rdy_en;
  logic             accept, run_hit, final_h1;
  logic             do_load, do_launch, do_idle, launch_bit;

  // Level driven in H0: NRZI toggles on a 1, Manchester sends the complement.
  function automatic logic enc_h0(input logic [1:0] m, input logic b, input logic lvl);
    case (m)
      2'b01:   enc_h0 = b ? ~lvl : lvl;
      2'b10:   enc_h0 = ~b;
      default: enc_h0 = b;
    endcase
  endfunction

  function automatic logic enc_h1(input logic [1:0] m, input logic b, input logic lvl);
    case (m)
      2'b01:   enc_h1 = lvl;
      2'b10:   enc_h1 = b;
      default: enc_h1 = b;
    endcase
  endfunction

  assign run_hit  = sen_r && (cnt == RUN);
  assign cnt_inc  = (cnt >= RUN) ? RUN : cnt + 1'b1;
  assign final_h1 = phase &&
                    (((state == DATA) && (bit_idx == '0) && !run_hit) ||
                     ((state == STUFF) && stuff_last));

  assign data_ready = rdy_en && ((state == IDLE) || final_h1);
  assign accept     = data_valid && data_ready;
  assign B_out      = b_reg;
  assign busy       = (state != IDLE);
  assign stuff_out  = (state == STUFF);

  always_comb begin
    state_n     = state;
    phase_n     = phase;
    idx_n       = bit_idx;
    shreg_n     = shreg;
    cnt_n       = cnt;
    mode_n      = mode_r;
    sen_n       = sen_r;
    last_n      = stuff_last;
    b_n         = b_reg;
    launch_mode = mode_r;
    do_load     = 1'b0;
    do_launch   = 1'b0;
    do_idle     = 1'b0;
    launch_bit  = 1'b0;

    case (state)
      IDLE: do_load = accept;
      DATA: begin
        if (!phase) begin
          phase_n = 1'b1;
          b_n     = enc_h1(mode_r, shreg[WIDTH-1], b_reg);
        end else if (run_hit) begin
          state_n = STUFF;
          phase_n = 1'b0;
          cnt_n   = '0;
          last_n  = (bit_idx == '0);
          shreg_n = shreg << 1;
          if (bit_idx != '0) idx_n = bit_idx - 1'b1;
          b_n     = enc_h0(mode_r, 1'b0, b_reg);
        end else if (bit_idx == '0) begin
          do_load = accept;
          do_idle = !accept;
        end else begin
          shreg_n    = shreg << 1;
          idx_n      = bit_idx - 1'b1;
          do_launch  = 1'b1;
          launch_bit = shreg[WIDTH-2];
        end
      end
      STUFF: begin
        if (!phase) begin
          phase_n = 1'b1;
          b_n     = enc_h1(mode_r, 1'b0, b_reg);
        end else if (stuff_last) begin
          do_load = accept;
          do_idle = !accept;
        end else begin
          // shreg was already advanced when the stuffed period began
          do_launch  = 1'b1;
          launch_bit = shreg[WIDTH-1];
        end
      end
      default: do_idle = 1'b1;
    endcase

    if (do_load) begin
      shreg_n     = data_in;
      idx_n       = LAST_IDX;
      mode_n      = mode;
      sen_n       = stuff_en;
      last_n      = 1'b0;
      launch_mode = mode;
      do_launch   = 1'b1;
      launch_bit  = data_in[WIDTH-1];
    end

    if (do_launch) begin
      state_n = DATA;
      phase_n = 1'b0;
      b_n     = enc_h0(launch_mode, launch_bit, b_reg);
      cnt_n   = launch_bit ? cnt_inc : '0;
    end

    if (do_idle) begin
      state_n = IDLE;
      phase_n = 1'b0;
      cnt_n   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= 1'b0;
      bit_idx    <= '0;
      cnt        <= '0;
      shreg      <= '0;
      mode_r     <= 2'b00;
      sen_r      <= 1'b0;
      stuff_last <= 1'b0;
      b_reg      <= 1'b0;
      rdy_en     <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      bit_idx    <= idx_n;
      cnt        <= cnt_n;
      shreg      <= shreg_n;
      mode_r     <= mode_n;
      sen_r      <= sen_n;
      stuff_last <= last_n;
      b_reg      <= b_n;
      rdy_en     <= 1'b1;
    end
  end

endmodule
